// File: rtl/sd_bd_queue.sv
// sd_bd_queue: buffer-descriptor queue between the host register
// interface and the SD data engine.
// Ports: clk, rst (async, active-low); master side we_m/dat_in_m,
//   free_bd/pend_bd/err_ovf; slave side re_s, ack_o_s/dat_out_s;
//   a_cmp retires the oldest in-flight descriptor.
// Option: SD_BD_FLUSH_EN adds a synchronous flush input.
module sd_bd_queue #(
   parameter  int DATA_W       = 32,
   parameter  int BD_NUM       = 8,
   parameter  int WORDS_PER_BD = 2,
   localparam int CW           = $clog2(BD_NUM + 1)
) (
   input  logic              clk,
   input  logic              rst,
`ifdef SD_BD_FLUSH_EN
   input  logic              flush,
`endif
   input  logic              we_m,
   input  logic [DATA_W-1:0] dat_in_m,
   output logic [CW-1:0]     free_bd,
   output logic [CW-1:0]     pend_bd,
   input  logic              re_s,
   output logic              ack_o_s,
   output logic [DATA_W-1:0] dat_out_s,
   input  logic              a_cmp,
   output logic              err_ovf
);

   localparam int DEPTH = BD_NUM * WORDS_PER_BD;
   localparam int PW    = $clog2(DEPTH);
   localparam int KW    = (WORDS_PER_BD > 1) ? $clog2(WORDS_PER_BD) : 1;
   localparam int BW    = $clog2(BD_NUM);

   localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);
   localparam logic [KW-1:0] K_LAST = KW'(WORDS_PER_BD - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BD_NUM - 1);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PW-1:0] wptr, rptr;
   logic [KW-1:0] wcnt, rcnt;
   logic [BW-1:0] cptr;
   logic [CW-1:0] inflight;

   logic [CW-1:0] free_nx, pend_nx, infl_nx;

   logic flush_i;
   logic partial;
   logic wr_acc, commit, ovf;
   logic rd_acc, fetched, retire;

`ifdef SD_BD_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   // An open descriptor already owns a slot counted in free_bd, so its
   // remaining words are always accepted.
   assign partial = (wcnt != '0);
   assign ovf     = we_m && (free_bd == '0) && !partial;
   assign wr_acc  = we_m && !ovf && !flush_i;
   assign commit  = wr_acc && (wcnt == K_LAST);

   // Reads only touch committed descriptors, never the open one.
   assign rd_acc  = re_s && !ack_o_s && (pend_bd != '0) && !flush_i;
   assign fetched = rd_acc && (rcnt == K_LAST);

   assign retire  = a_cmp && (inflight != '0) && !flush_i;

   always_comb begin
      free_nx = free_bd;
      pend_nx = pend_bd;
      infl_nx = inflight;
      if (commit) begin
         free_nx = free_nx - CW'(1);
         pend_nx = pend_nx + CW'(1);
      end
      if (fetched) begin
         pend_nx = pend_nx - CW'(1);
         infl_nx = infl_nx + CW'(1);
      end
      if (retire) begin
         infl_nx = infl_nx - CW'(1);
         free_nx = free_nx + CW'(1);
      end
   end

   // Descriptor storage carries no reset; validity lives in the counters.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wptr] <= dat_in_m;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr      <= '0;
         rptr      <= '0;
         wcnt      <= '0;
         rcnt      <= '0;
         cptr      <= '0;
         inflight  <= '0;
         free_bd   <= CW'(BD_NUM);
         pend_bd   <= '0;
         ack_o_s   <= 1'b0;
         dat_out_s <= '0;
         err_ovf   <= 1'b0;
      end else if (flush_i) begin
         wptr     <= '0;
         rptr     <= '0;
         wcnt     <= '0;
         rcnt     <= '0;
         cptr     <= '0;
         inflight <= '0;
         free_bd  <= CW'(BD_NUM);
         pend_bd  <= '0;
         ack_o_s  <= 1'b0;
         err_ovf  <= 1'b0;
      end else begin
         free_bd  <= free_nx;
         pend_bd  <= pend_nx;
         inflight <= infl_nx;
         ack_o_s  <= rd_acc;
         err_ovf  <= ovf;
         if (wr_acc) begin
            wptr <= (wptr == P_LAST) ? '0 : wptr + PW'(1);
            wcnt <= (wcnt == K_LAST) ? '0 : wcnt + KW'(1);
         end
         if (rd_acc) begin
            dat_out_s <= mem[rptr];
            rptr      <= (rptr == P_LAST) ? '0 : rptr + PW'(1);
            rcnt      <= (rcnt == K_LAST) ? '0 : rcnt + KW'(1);
         end
         if (retire) begin
            cptr <= (cptr == B_LAST) ? '0 : cptr + BW'(1);
         end
      end
   end

endmodule

// File: doc/sd_bd_queue.md
# sd_bd_queue

Parametrised buffer-descriptor queue for the SD host controller, the next-generation replacement for the fixed two-word descriptor store. The bus master writes descriptors word by word, the SD data engine fetches them in order and returns each one with a completion pulse. The block tracks three descriptor populations: free, pending (written, not yet fetched) and in-flight (fetched, not yet completed). It sits between the host register interface and the SD data-transfer state machine.

## Interface
- DATA_W, 32, width of one descriptor word
- BD_NUM, 8, descriptor slots (≥2)
- WORDS_PER_BD, 2, words per descriptor (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- we_m  in  1  master word write strobe
- dat_in_m  in  DATA_W  master write word
- free_bd  out  $clog2(BD_NUM+1)  free descriptor slots
- pend_bd  out  $clog2(BD_NUM+1)  committed descriptors awaiting fetch
- re_s  in  1  slave read request
- ack_o_s  out  1  read acknowledge, dat_out_s valid
- dat_out_s  out  DATA_W  fetched word
- a_cmp  in  1  completion pulse, retires oldest in-flight descriptor
- err_ovf  out  1  one-cycle pulse: master write dropped

## Operation
- Storage: BD_NUM*WORDS_PER_BD words, circular. Pointers: write word pointer, read word pointer, completion descriptor pointer; each wraps to 0 after its last index (no power-of-two requirement).
- Write: we_m=1 and a slot free (free_bd>0 or a partial descriptor is open) -> store word, advance write pointer. On the WORDS_PER_BD-th word the descriptor commits: free_bd-1, pend_bd+1 on the next edge.
- Overflow: we_m=1, free_bd=0, no partial open -> word dropped, err_ovf=1 next cycle, pointers unchanged.
- Read: accepted when re_s=1, ack_o_s=0, pend_bd>0. The next cycle ack_o_s=1 and dat_out_s=word. After the WORDS_PER_BD-th accepted read of a descriptor, pend_bd-1 and the descriptor becomes in-flight. re_s with pend_bd=0 -> no ack; the request may be held until accepted.
- Completion: a_cmp=1 with in-flight count>0 -> free_bd+1. a_cmp with no in-flight descriptor is ignored.
- Simultaneous events in one cycle are all applied; counters take the net delta. Example: commit + a_cmp -> free_bd unchanged. Reads of a pending descriptor never alias the open write descriptor.
- Invariant: free_bd + pend_bd + in-flight = BD_NUM.

## Timing
- Reset values: free_bd=BD_NUM, pend_bd=0, ack_o_s=0, dat_out_s=0, err_ovf=0; all pointers 0, in-flight 0.
- Reset mid-operation clears the open partial descriptor and all pending and in-flight state immediately (asynchronous).
- Read latency 1 cycle; ack_o_s is high exactly one cycle per accepted read; maximum read rate is one word every 2 cycles.
- dat_out_s holds its value until the next accepted read.
- Write accepted every cycle; counters update on the edge after the committing write.
- a_cmp is sampled per cycle; an a_cmp held for N cycles retires up to N descriptors.

## Configuration
- SD_BD_FLUSH_EN defined: adds input port flush (1 bit, synchronous). flush=1 returns all pointers and counters to reset values on the next edge, without touching dat_out_s. flush has priority over same-cycle we_m, re_s and a_cmp; ack_o_s is forced to 0 that cycle.
- SD_BD_FLUSH_EN undefined: no flush port; state clears only via rst.

## Test plan
Parameters for all scenarios: DATA_W=32, BD_NUM=4, WORDS_PER_BD=2.
- Reset, idle -> free_bd=4, pend_bd=0, ack_o_s=0, dat_out_s=0.
- Write 0xA0,0xA1 -> free_bd=3, pend_bd=1. Then 2 reads -> ack pulses carrying 0xA0 then 0xA1; pend_bd=0, free_bd=3. Then a_cmp -> free_bd=4.
- Write 8 words, then a 9th (0xFF) -> err_ovf pulse; free_bd=0. Fetch and complete one descriptor, then write 2 words -> wrap to slot 0 and read back correctly.
- re_s held with pend_bd=0 -> no ack. Complete a descriptor write -> ack 1 cycle after acceptance. a_cmp with nothing in flight -> free_bd unchanged.
- Same-cycle commit and a_cmp with one descriptor in flight -> free_bd unchanged, pend_bd+1.
- Assert rst after 1 of 2 words written and with 1 descriptor in flight -> free_bd=4. With SD_BD_FLUSH_EN: flush with a same-cycle we_m -> all counters at reset values, write discarded.
